seg7_capture: RTL and testbench
===============================

SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 3: consecutive identical samples needed to accept a digit (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 1024: samples without a completed frame before lock is lost (legal range 2..65535).
REQ-003 clk  input  1  single clock; all logic updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sample_en  input  1  sampling strobe; an and leds are evaluated only on cycles where sample_en=1.
REQ-006 an  input  4  observed digit enables, active-low; an[i]=0 selects digit i.
REQ-007 leds  input  7  observed segments, active-low, order abcdefg, with a in bit 6.
REQ-008 digits  output  16  last complete frame; digit i is held in bits [4i+3:4i].
REQ-009 err  output  4  per-digit flag for an unrecognised pattern in the last frame.
REQ-010 frame_valid  output  1  one-cycle pulse when digits and err update.
REQ-011 locked  output  1  high while frames keep arriving within TIMEOUT samples.

Function
REQ-012 A sample SHALL be valid only when an has exactly one zero bit; otherwise the stability count SHALL clear and no write SHALL occur.
REQ-013 Stability: a valid sample whose (an, leds) equals the previous valid sample SHALL increment the count, saturating at STABLE_CNT.
- Any other valid sample SHALL set the count to 1.
REQ-014 The slot for the selected digit SHALL be written exactly once per stable run, on the sample where the count first equals STABLE_CNT.
- With STABLE_CNT=1 this is the first sample of the run.
REQ-015 Decode SHALL map patterns as follows.
- 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0001100->9.
- 1111111 (blank) -> 4'hF with err=0.
- Any other pattern, including 0110000, -> 4'hE with err=1.
REQ-016 Each write SHALL set mask bit i. Rewriting a slot already set SHALL overwrite its value and leave the mask unchanged.
REQ-017 On the edge where a write makes the mask 4'b1111, the block SHALL:
- load digits/err from the capture slots, including the value written on that edge;
- assert frame_valid for exactly one cycle;
- clear the mask.
REQ-018 frame_valid SHALL be high in the cycle immediately after the completing sample_en cycle; the latency from that sample_en edge to the pulse is 1 clock.
REQ-019 digits and err SHALL hold their values between frame_valid pulses.
REQ-020 The state machine SHALL have three states: IDLE, CAPTURE and LOCKED.
- IDLE->CAPTURE on the first valid sample.
- CAPTURE->LOCKED on frame completion.
- LOCKED->CAPTURE when the timeout counter reaches TIMEOUT.
- LOCKED stays LOCKED on each frame completion.
REQ-021 The timeout counter SHALL increment on every sample_en, clear on frame completion, and saturate at TIMEOUT.
REQ-022 On the LOCKED->CAPTURE transition the mask SHALL clear, while digits and err SHALL be retained.
REQ-023 locked SHALL equal (state==LOCKED), driven from a register.
REQ-024 When a completing write and the timeout expiry fall on the same edge, completion SHALL win: the block stays or goes LOCKED and the counter clears.

Reset
REQ-025 While reset=1, on every edge, the block SHALL apply:
- digits=16'h0000, err=4'h0, frame_valid=0, locked=0;
- mask=0, stability count=0, timeout counter=0;
- previous-sample registers=0, state=IDLE.
REQ-026 Reset SHALL override sample_en; a partially captured frame SHALL be discarded and no frame_valid SHALL follow reset release.

Structure
REQ-027 The ten digit patterns, the blank pattern and the state encodings SHALL be defined in the shared package seg7_pkg, so the existing decoder and this block use one table.
REQ-028 The pattern->{bcd, err} mapping SHALL be a combinational sub-module, seg7_pattern_decode, instantiated once.

Verification
REQ-029 Bench SHALL cover a clean frame:
- STABLE_CNT=3; each of an=1110,1101,1011,0111 held for 3 samples with leds 0010010,0000110,1001100,0100100.
- Expect one frame_valid, digits=16'h5432, err=0, locked=1.
REQ-030 Bench SHALL cover glitch rejection:
- digit 0 shown for 2 samples, then an=1100 for 1 sample, then digit 0 again for 2 samples.
- Expect no write until a fresh 3-sample run.
REQ-031 Bench SHALL cover a bad pattern: slot 2 receives 0110000 -> digits[11:8]=4'hE, err=4'b0100.
REQ-032 Bench SHALL cover timeout:
- TIMEOUT=8, locked=1, then 8 samples with an=1111.
- Expect locked=0 on the edge after the 8th sample and digits unchanged.
REQ-033 Bench SHALL cover reset mid-frame:
- 3 slots written, reset pulsed for 1 cycle, then the 4th digit completed.
- Expect no frame_valid and all outputs at reset values.
REQ-034 Bench SHALL cover the simultaneous case: a completing write on the edge where the timeout counter reaches TIMEOUT -> frame_valid=1 and locked stays 1.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment pattern table, capture states and digit-select helpers
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low abcdefg patterns; index i is the glyph for digit value i.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0001100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
        7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_LOCKED  = 2'd2
    } cap_state_t;

    function automatic logic one_zero(input logic [3:0] an);
        logic [2:0] zeros;
        zeros = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) zeros = zeros + 3'd1;
        end
        return zeros == 3'd1;
    endfunction

    function automatic logic [1:0] zero_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational segment pattern to {bcd, err} decoder
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       err
);

    always_comb begin
        bcd = 4'hE;
        err = 1'b1;
        if (pattern == SEG_BLANK) begin
            bcd = 4'hF;
            err = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            if (pattern == SEG_DIGITS[i]) begin
                bcd = 4'(i);
                err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - recovers a 4-digit frame from a multiplexed seven-segment display
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CNT = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_en,
    input  logic [3:0]  an,
    input  logic [6:0]  leds,
    output logic [15:0] digits,
    output logic [3:0]  err,
    output logic        frame_valid,
    output logic        locked
);

    localparam logic [3:0]  STAB_MAX = 4'(STABLE_CNT);
    localparam logic [15:0] TMO_MAX  = 16'(TIMEOUT);

    cap_state_t  state;
    logic [3:0]  stab_cnt;
    logic [3:0]  prev_an;
    logic [6:0]  prev_leds;
    logic [3:0]  mask;
    logic [15:0] slot_bcd;
    logic [3:0]  slot_err;
    logic [15:0] tmo_cnt;

    logic        valid;
    logic        match;
    logic [3:0]  stab_inc;
    logic [3:0]  stab_nxt;
    logic        write;
    logic [1:0]  sel;
    logic [3:0]  mask_nxt;
    logic        complete;
    logic [15:0] tmo_inc;
    logic        expire;
    logic [3:0]  dec_bcd;
    logic        dec_err;
    logic [15:0] bcd_w;
    logic [3:0]  err_w;

    seg7_pattern_decode u_decode (
        .pattern (leds),
        .bcd     (dec_bcd),
        .err     (dec_err)
    );

    always_comb begin
        valid    = sample_en && one_zero(an);
        match    = (an == prev_an) && (leds == prev_leds);
        stab_inc = (stab_cnt >= STAB_MAX) ? STAB_MAX : stab_cnt + 4'd1;
        stab_nxt = match ? stab_inc : 4'd1;
        // A saturated count on a matching sample is the tail of a run already written.
        write    = valid && (stab_nxt == STAB_MAX) && !(match && stab_cnt == STAB_MAX);
        sel      = zero_index(an);
        mask_nxt = mask | (4'b0001 << sel);
        complete = write && (mask_nxt == 4'hF);
        tmo_inc  = (tmo_cnt >= TMO_MAX) ? TMO_MAX : tmo_cnt + 16'd1;
        expire   = sample_en && (state == ST_LOCKED) && (tmo_inc == TMO_MAX);
        bcd_w    = slot_bcd;
        bcd_w[{sel, 2'b00} +: 4] = dec_bcd;
        err_w    = slot_err;
        err_w[sel] = dec_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            locked      <= 1'b0;
            digits      <= '0;
            err         <= '0;
            frame_valid <= 1'b0;
            mask        <= '0;
            stab_cnt    <= '0;
            tmo_cnt     <= '0;
            prev_an     <= '0;
            prev_leds   <= '0;
            slot_bcd    <= '0;
            slot_err    <= '0;
        end else begin
            frame_valid <= 1'b0;
            if (sample_en) tmo_cnt <= tmo_inc;
            if (valid) begin
                prev_an   <= an;
                prev_leds <= leds;
                stab_cnt  <= stab_nxt;
            end else if (sample_en) begin
                stab_cnt <= '0;
            end
            if (write) begin
                slot_bcd <= bcd_w;
                slot_err <= err_w;
                mask     <= mask_nxt;
            end
            // Completion outranks a timeout expiring on the same edge.
            if (complete) begin
                digits      <= bcd_w;
                err         <= err_w;
                frame_valid <= 1'b1;
                mask        <= '0;
                tmo_cnt     <= '0;
                state       <= ST_LOCKED;
                locked      <= 1'b1;
            end else if (expire) begin
                state  <= ST_CAPTURE;
                locked <= 1'b0;
                mask   <= '0;
            end else if (state == ST_IDLE && valid) begin
                state <= ST_CAPTURE;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - randomized and directed bench for seg7_capture against a behavioural model
module tb_seg7_capture;

    localparam int S_A = 3;
    localparam int S_B = 2;
    localparam int TMO = 8;

    localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010, P3 = 7'b0000110;
    localparam logic [6:0] P4 = 7'b1001100, P5 = 7'b0100100, P6 = 7'b0100000, P7 = 7'b0001111;
    localparam logic [6:0] P8 = 7'b0000000, P9 = 7'b0001100, PBL = 7'b1111111, PBAD = 7'b0110000;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en;
    logic [3:0]  an;
    logic [6:0]  leds;
    logic [15:0] digits_a, digits_b;
    logic [3:0]  err_a, err_b;
    logic        fv_a, fv_b, locked_a, locked_b;

    always #5 clk = ~clk;

    seg7_capture #(.STABLE_CNT(S_A), .TIMEOUT(TMO)) u_a (
        .clk(clk), .reset(reset), .sample_en(sample_en), .an(an), .leds(leds),
        .digits(digits_a), .err(err_a), .frame_valid(fv_a), .locked(locked_a)
    );

    seg7_capture #(.STABLE_CNT(S_B), .TIMEOUT(TMO)) u_b (
        .clk(clk), .reset(reset), .sample_en(sample_en), .an(an), .leds(leds),
        .digits(digits_b), .err(err_b), .frame_valid(fv_b), .locked(locked_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    // Model: run length of identical valid samples, written-slot set, frame outputs, lock timer.
    int         m_len[2];
    logic [3:0] m_pan[2];
    logic [6:0] m_pleds[2];
    logic [3:0] m_mask[2];
    logic [3:0] m_slot[2][4];
    logic       m_serr[2][4];
    logic [15:0] m_digits[2];
    logic [3:0] m_err[2];
    logic       m_fv[2];
    int         m_state[2];
    int         m_tmo[2];

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        case (p)
            7'b0000001: return {4'd0, 1'b0};
            7'b1001111: return {4'd1, 1'b0};
            7'b0010010: return {4'd2, 1'b0};
            7'b0000110: return {4'd3, 1'b0};
            7'b1001100: return {4'd4, 1'b0};
            7'b0100100: return {4'd5, 1'b0};
            7'b0100000: return {4'd6, 1'b0};
            7'b0001111: return {4'd7, 1'b0};
            7'b0000000: return {4'd8, 1'b0};
            7'b0001100: return {4'd9, 1'b0};
            7'b1111111: return {4'hF, 1'b0};
            default:    return {4'hE, 1'b1};
        endcase
    endfunction

    task automatic model_step(input int k, input int s);
        int zeros;
        int idx;
        logic [4:0] d;
        bit complete;
        if (reset) begin
            m_len[k] = 0; m_pan[k] = '0; m_pleds[k] = '0; m_mask[k] = '0;
            for (int i = 0; i < 4; i++) begin m_slot[k][i] = '0; m_serr[k][i] = 1'b0; end
            m_digits[k] = '0; m_err[k] = '0; m_fv[k] = 1'b0; m_state[k] = 0; m_tmo[k] = 0;
        end else begin
            m_fv[k] = 1'b0;
            complete = 1'b0;
            zeros = 0;
            idx = 0;
            for (int i = 0; i < 4; i++) if (!an[i]) begin zeros++; idx = i; end
            if (sample_en && m_tmo[k] < TMO) m_tmo[k]++;
            if (sample_en && zeros == 1) begin
                if (an == m_pan[k] && leds == m_pleds[k]) m_len[k]++;
                else m_len[k] = 1;
                m_pan[k] = an;
                m_pleds[k] = leds;
                if (m_state[k] == 0) m_state[k] = 1;
                if (m_len[k] == s) begin
                    d = ref_decode(leds);
                    m_slot[k][idx] = d[4:1];
                    m_serr[k][idx] = d[0];
                    m_mask[k][idx] = 1'b1;
                    if (m_mask[k] == 4'hF) complete = 1'b1;
                end
            end else if (sample_en) begin
                m_len[k] = 0;
            end
            if (complete) begin
                for (int i = 0; i < 4; i++) begin
                    m_digits[k][4*i +: 4] = m_slot[k][i];
                    m_err[k][i] = m_serr[k][i];
                end
                m_fv[k] = 1'b1;
                m_mask[k] = '0;
                m_tmo[k] = 0;
                m_state[k] = 2;
            end else if (m_state[k] == 2 && sample_en && m_tmo[k] == TMO) begin
                m_state[k] = 1;
                m_mask[k] = '0;
            end
        end
    endtask

    task automatic cycle(input logic rst, input logic sen, input logic [3:0] a, input logic [6:0] l);
        @(negedge clk);
        reset = rst; sample_en = sen; an = a; leds = l;
        @(posedge clk);
        model_step(0, S_A);
        model_step(1, S_B);
        #1;
        check_eq("digits_a", digits_a, m_digits[0]);
        check_eq("err_a", err_a, m_err[0]);
        check_eq("frame_valid_a", fv_a, m_fv[0]);
        check_eq("locked_a", locked_a, m_state[0] == 2);
        check_eq("digits_b", digits_b, m_digits[1]);
        check_eq("err_b", err_b, m_err[1]);
        check_eq("frame_valid_b", fv_b, m_fv[1]);
        check_eq("locked_b", locked_b, m_state[1] == 2);
    endtask

    task automatic show(input logic [3:0] a, input logic [6:0] l, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, a, l);
    endtask

    logic [6:0] pats[12];

    initial begin
        logic [3:0] ra;
        logic [6:0] rl;
        int         rn;
        pats = '{P0, P1, P2, P3, P4, P5, P6, P7, P8, P9, PBL, PBAD};
        reset = 1'b1; sample_en = 1'b0; an = 4'hF; leds = 7'h7F;
        cycle(1'b1, 1'b0, 4'hF, 7'h7F);
        cycle(1'b1, 1'b1, 4'b1110, P3);
        check_eq("rst_digits", digits_a, 16'h0000);
        check_eq("rst_err", err_a, 4'h0);
        check_eq("rst_fv", fv_a, 1'b0);
        check_eq("rst_locked", locked_a, 1'b0);

        // Clean frame, then timeout.
        show(4'b1110, P2, 3); show(4'b1101, P3, 3); show(4'b1011, P4, 3); show(4'b0111, P5, 3);
        check_eq("clean_fv", fv_a, 1'b1);
        check_eq("clean_digits", digits_a, 16'h5432);
        check_eq("clean_err", err_a, 4'h0);
        check_eq("clean_locked", locked_a, 1'b1);
        cycle(1'b0, 1'b0, 4'hF, P5);
        check_eq("clean_fv_pulse", fv_a, 1'b0);
        show(4'b1111, P5, 7);
        check_eq("tmo_still_locked", locked_a, 1'b1);
        show(4'b1111, P5, 1);
        check_eq("tmo_unlocked", locked_a, 1'b0);
        check_eq("tmo_digits_kept", digits_a, 16'h5432);

        // Glitch rejection.
        cycle(1'b1, 1'b0, 4'hF, 7'h7F);
        show(4'b1110, P7, 2); show(4'b1100, P7, 1); show(4'b1110, P7, 2);
        show(4'b1101, P1, 3); show(4'b1011, P8, 3); show(4'b0111, P9, 3);
        check_eq("glitch_no_frame", fv_a, 1'b0);
        check_eq("glitch_digits", digits_a, 16'h0000);
        show(4'b1110, P7, 3);
        check_eq("glitch_fresh_fv", fv_a, 1'b1);
        check_eq("glitch_digits_after", digits_a, 16'h9817);

        // Unrecognised pattern in slot 2, blank in slot 1.
        cycle(1'b1, 1'b0, 4'hF, 7'h7F);
        show(4'b1110, P0, 3); show(4'b1101, PBL, 3); show(4'b1011, PBAD, 3); show(4'b0111, P6, 3);
        check_eq("bad_fv", fv_a, 1'b1);
        check_eq("bad_slot2", digits_a[11:8], 4'hE);
        check_eq("bad_err", err_a, 4'b0100);
        check_eq("bad_digits", digits_a, 16'h6EF0);

        // Reset mid-frame, sample_en held high during reset.
        cycle(1'b1, 1'b0, 4'hF, 7'h7F);
        show(4'b1110, P1, 3); show(4'b1101, P2, 3); show(4'b1011, P3, 3);
        cycle(1'b1, 1'b1, 4'b0111, P4);
        show(4'b0111, P4, 3);
        check_eq("midrst_fv", fv_a, 1'b0);
        check_eq("midrst_digits", digits_a, 16'h0000);
        check_eq("midrst_err", err_a, 4'h0);
        check_eq("midrst_locked", locked_a, 1'b0);

        // Completion and timeout on the same edge (instance b: 2 samples per digit).
        cycle(1'b1, 1'b0, 4'hF, 7'h7F);
        show(4'b1110, P9, 2); show(4'b1101, P8, 2); show(4'b1011, P6, 2); show(4'b0111, P4, 2);
        check_eq("sim_first_fv", fv_b, 1'b1);
        check_eq("sim_first_digits", digits_b, 16'h4689);
        show(4'b1110, P1, 2); show(4'b1101, P3, 2); show(4'b1011, P5, 2); show(4'b0111, P7, 1);
        check_eq("sim_locked_before", locked_b, 1'b1);
        show(4'b0111, P7, 1);
        check_eq("sim_fv", fv_b, 1'b1);
        check_eq("sim_locked", locked_b, 1'b1);
        check_eq("sim_digits", digits_b, 16'h7531);

        // Randomized runs.
        for (int r = 0; r < 400; r++) begin
            if ($urandom_range(0, 7) == 0) ra = 4'($urandom);
            else ra = ~(4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) rl = 7'($urandom);
            else rl = pats[$urandom_range(0, 11)];
            rn = $urandom_range(1, 5);
            for (int j = 0; j < rn; j++) begin
                cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ra, rl);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
